nibble_op_sequencer: RTL and testbench

- Button-triggered controller for the Basys3 switch/LED/seven-segment nibble logic unit.
- Debounces a "go" button, then captures operands A = sw[3:0] and B = sw[7:4] and opcode sw[15:14].
- Executes one 4-bit operation, latches the result onto the LEDs, and time-multiplexes the four seven-segment digits to show result, B, A and opcode.
- Sits directly between board I/O and the top-level constraints wrapper.

---
 rtl/nibble_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/nibble_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_nibble_op_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// rtl/nibble_pkg.sv - shared types and constants for the nibble op sequencer
// Contents: FSM state encoding, opcode values, blank pattern and the
// active-low {g,f,e,d,c,b,a} hex-to-segment table.
package nibble_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_EXEC    = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry [i] is the segment pattern for hex digit i (listed F down to 0).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debouncer and rising-edge pulse
// Ports: clk, rst (sync active-high), btn_i (raw asynchronous button),
//        go_pulse_o (one-cycle pulse on each accepted press).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic go_pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_dly_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            // Any return to the accepted level restarts the hold window.
            if (sync2_q != stable_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign go_pulse_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/nibble_op_sequencer.sv
// rtl/nibble_op_sequencer.sv - button-triggered 4-bit ALU with LED and 7-seg scan
// Ports: clk, rst (sync active-high), sw[15:0] (A=[3:0], B=[7:4], op=[15:14]),
//        btn_go (raw button), seg/an (active-low display), led (result),
//        carry (ADD carry-out), busy (not idle), done (result-latched pulse).
module nibble_op_sequencer
    import nibble_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_go,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [3:0]  led,
    output logic        carry,
    output logic        busy,
    output logic        done
);

    localparam int RW = $clog2(REFRESH_CYCLES + 1);

    logic          go_pulse;
    state_e        state_q, state_d;
    logic [3:0]    a_q, b_q, res_q;
    logic [1:0]    op_q;
    logic          carry_q;
    logic [3:0]    alu_res;
    logic          alu_carry;
    logic [4:0]    sum;
    logic [RW-1:0] ref_q;
    logic [1:0]    digit_q;
    logic [3:0]    digit_val;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_go),
        .go_pulse_o(go_pulse)
    );

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (go_pulse) state_d = S_CAPTURE;
            end
            S_CAPTURE: state_d = S_EXEC;
            S_EXEC:    state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        alu_carry = 1'b0;
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_OR:   alu_res = a_q | b_q;
            default: begin
                alu_res   = sum[3:0];
                alu_carry = sum[4];
            end
        endcase
    end

    // The result register is written on leaving EXEC, so led/carry are
    // already valid in the same cycle that done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_CAPTURE) begin
                a_q  <= sw[3:0];
                b_q  <= sw[7:4];
                op_q <= sw[15:14];
            end
            if (state_q == S_EXEC) begin
                res_q   <= alu_res;
                carry_q <= alu_carry;
            end
        end
    end

    assign led   = res_q;
    assign carry = carry_q;

    always_comb begin
        case (digit_q)
            2'd0:    digit_val = res_q;
            2'd1:    digit_val = b_q;
            2'd2:    digit_val = a_q;
            default: digit_val = {2'b00, op_q};
        endcase
    end

    // an and seg come from the same digit index in the same register stage,
    // so a frame never pairs one digit's anode with another's pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q   <= '0;
            digit_q <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'hF;
        end else begin
            if (ref_q == RW'(REFRESH_CYCLES - 1)) begin
                ref_q   <= '0;
                digit_q <= digit_q + 2'd1;
            end else begin
                ref_q <= ref_q + RW'(1);
            end
            seg_q <= HEX_SEG[digit_val];
            an_q  <= ~(4'b0001 << digit_q);
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_nibble_op_sequencer.sv
// tb/tb_nibble_op_sequencer.sv - self-checking bench for nibble_op_sequencer
module tb_nibble_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        btn_go;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [3:0]  led;
    logic        carry;
    logic        busy;
    logic        done;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference view of what the display should hold after the last op.
    logic [3:0] m_res, m_a, m_b;
    logic [1:0] m_op;
    logic       m_carry;

    nibble_op_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .btn_go(btn_go),
        .seg   (seg),
        .an    (an),
        .led   (led),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural op: plain integer arithmetic on the switch fields.
    task automatic model(input logic [15:0] s);
        int a, b, r;
        a = int'(s[3:0]);
        b = int'(s[7:4]);
        case (int'(s[15:14]))
            0:       r = a & b;
            1:       r = a ^ b;
            2:       r = a | b;
            default: r = a + b;
        endcase
        m_a     = s[3:0];
        m_b     = s[7:4];
        m_op    = s[15:14];
        m_res   = 4'(r % 16);
        m_carry = (r >= 16);
    endtask

    // Press for 'hold' cycles; optionally change switches during EXEC or
    // re-press briefly while the FSM is busy.
    task automatic do_op(input logic [15:0] s, input int hold, input bit chg, input bit press2);
        int dn0, t0;
        model(s);
        dn0    = done_cnt;
        sw     = s;
        btn_go = 1'b1;
        t0     = cyc;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == hold) btn_go = 1'b0;
            if (chg && k == 8) sw = 16'h80FF;
            if (press2 && k == 8) btn_go = 1'b1;
            if (press2 && k == 10) btn_go = 1'b0;
        end
        chk("done_count", done_cnt, dn0 + 1);
        chk("latency", done_cyc - t0, 9);
        chk("led", led, m_res);
        chk("carry", carry, m_carry);
        chk("busy_idle", busy, 0);
    endtask

    task automatic check_disp();
        logic [3:0] vals [4];
        bit seen [4];
        vals = '{m_res, m_b, m_a, {2'b00, m_op}};
        seen = '{0, 0, 0, 0};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (!seen[d] && an === (4'hF ^ (4'h1 << d))) begin
                    seen[d] = 1;
                    chk($sformatf("digit%0d_seg", d), seg, segtab[vals[d]]);
                end
            end
        end
        for (int d = 0; d < 4; d++) chk($sformatf("digit%0d_seen", d), seen[d], 1);
    endtask

    initial begin
        int dn0;
        logic [15:0] s;
        rst    = 1'b1;
        sw     = 16'h0;
        btn_go = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_led", led, 0);
        chk("rst_carry", carry, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Free-running scan from reset release: 8 cycles per digit, all '0'
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("scan_an%0d", i), an, 4'hF ^ (4'h1 << ((i / 8) % 4)));
            chk($sformatf("scan_seg%0d", i), seg, 7'h40);
            chk("scan_onehot", $countones(~an), 1);
        end

        // Directed XOR and ADD-with-wrap
        do_op(16'h4035, 10, 0, 0);
        check_disp();
        do_op(16'hC02F, 10, 0, 0);
        check_disp();

        // Bouncing press then bouncing release
        s = 16'(($urandom & 32'h0000_C0FF));
        model(s);
        sw  = s;
        dn0 = done_cnt;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) btn_go = ~btn_go;
            @(negedge clk);
        end
        chk("bounce_press_quiet", done_cnt, dn0);
        btn_go = 1'b1;
        repeat (16) @(negedge clk);
        chk("bounce_one_done", done_cnt, dn0 + 1);
        chk("bounce_led", led, m_res);
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) btn_go = ~btn_go;
            @(negedge clk);
        end
        btn_go = 1'b0;
        repeat (16) @(negedge clk);
        chk("bounce_release", done_cnt, dn0 + 1);

        // Switches change during EXEC: result must use captured operands
        do_op(16'h4096, 10, 1, 0);
        check_disp();
        // Short second press while busy is ignored
        do_op(16'hC0A7, 7, 0, 1);

        // Randomized operations with random hold length
        for (int n = 0; n < 8; n++) begin
            s = 16'($urandom);
            do_op(s, 6 + int'($urandom_range(0, 6)), 0, 0);
        end
        check_disp();

        // Reset asserted during EXEC after a nonzero result
        do_op(16'h4035, 10, 0, 0);
        dn0    = done_cnt;
        sw     = 16'($urandom);
        btn_go = 1'b1;
        for (int k = 1; k <= 8; k++) @(negedge clk);
        chk("midop_busy_exec", busy, 1);
        rst    = 1'b1;
        btn_go = 1'b0;
        @(negedge clk);
        chk("midop_rst_led", led, 0);
        chk("midop_rst_busy", busy, 0);
        chk("midop_rst_done", done, 0);
        chk("midop_rst_an", an, 4'hF);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        chk("midop_no_done", done_cnt, dn0);
        chk("midop_led_after", led, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
